// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the fetch PC sequencer
//
// Purpose: FSM state encoding and default widths/vectors used by pc_sequencer.
// Contents:
//   XLEN        default PC / address width
//   RESET_VEC   default PC loaded on reset
//   ILEN_B      instruction size in bytes (sequential PC increment)
//   pcs_state_e sequencer states BOOT / FETCH / HOLD
package pc_pkg;

  localparam int          XLEN      = 64;
  localparam logic [63:0] RESET_VEC = 64'h0;
  localparam int          ILEN_B    = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } pcs_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC owner and instruction fetch sequencer
//
// Purpose: owns the fetch PC, issues imem requests, holds the fetched word
// until decode accepts it, then advances the PC. Trap and branch/jump
// redirects retarget the PC and kill any fetch already in flight.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata     instruction memory port (addr = pc)
//   instr_valid/ready/instr/pc  handshake towards decode
//   redirect_valid/pc           branch/jump target pulse
//   trap_valid/vec              trap target pulse (wins over redirect)
//   misalign_err                1-cycle pulse when an accepted target had [1:0]!=0
//   pc                          current architectural next-fetch PC
module pc_sequencer #(
  parameter int               XLEN      = pc_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_VEC = pc_pkg::RESET_VEC,
  parameter int               ILEN_B    = pc_pkg::ILEN_B
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  output logic            misalign_err,
  output logic [XLEN-1:0] pc
);

  import pc_pkg::*;

  pcs_state_e      state;
  logic            kill;
  logic [XLEN-1:0] pend_pc;

  logic            redir;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] tgt_al;
  logic            tgt_mis;

  // Trap outranks a same-cycle branch/jump redirect.
  assign redir   = trap_valid | redirect_valid;
  assign tgt     = trap_valid ? trap_vec : redirect_pc;
  assign tgt_al  = {tgt[XLEN-1:2], 2'b00};
  assign tgt_mis = |tgt[1:0];

  // The request address is the PC itself; the PC never moves while a
  // request is outstanding, which keeps imem_addr stable until ack.
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= BOOT;
      pc           <= RESET_VEC;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      instr        <= '0;
      instr_pc     <= '0;
      misalign_err <= 1'b0;
      kill         <= 1'b0;
      pend_pc      <= '0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (imem_ack) begin
            if (redir) begin
              // Newest target wins over anything parked in pend_pc.
              pc           <= tgt_al;
              kill         <= 1'b0;
              misalign_err <= tgt_mis;
            end else if (kill) begin
              pc   <= pend_pc;
              kill <= 1'b0;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= HOLD;
            end
          end else if (redir) begin
            // Address must stay put until the outstanding ack; park the target.
            pend_pc      <= tgt_al;
            kill         <= 1'b1;
            misalign_err <= tgt_mis;
          end
        end

        HOLD: begin
          if (redir) begin
            pc           <= tgt_al;
            misalign_err <= tgt_mis;
            instr_valid  <= 1'b0;
            imem_req     <= 1'b1;
            state        <= FETCH;
          end else if (instr_ready) begin
            pc          <= pc + XLEN'(ILEN_B);
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end

        default: begin
          state       <= BOOT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk;
  logic        resetn;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        trap_valid;
  logic [63:0] trap_vec;
  logic        misalign_err;
  logic [63:0] pc;

  int checks = 0;
  int errors = 0;

  logic        auto_ack;
  logic        man_ack;
  int          ack_lat;
  int          wait_cnt;

  logic [95:0] exp_q[$];
  logic [95:0] obs_q[$];

  pc_sequencer dut (
    .clk            (clk),
    .resetn         (resetn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_vec       (trap_vec),
    .misalign_err   (misalign_err),
    .pc             (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Memory model: acks after ack_lat waiting cycles, or follows man_ack.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    wait_cnt   = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!auto_ack) begin
        imem_ack   = man_ack;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
      end else if (imem_req) begin
        if (imem_ack) wait_cnt = 0;
        if (wait_cnt >= ack_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Decode-side monitor: record every accepted instruction.
  always @(negedge clk) begin
    if (resetn && instr_valid && instr_ready)
      obs_q.push_back({instr_pc, instr});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; auto_ack = 1'b1; man_ack = 1'b0; ack_lat = 0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    trap_valid = 1'b0; trap_vec = '0;
    step(); step();
    @(negedge clk);
    checks++;
    if ({imem_req, instr_valid, misalign_err} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b want 000", {imem_req, instr_valid, misalign_err});
    end
    checks++;
    if (pc !== 64'h0 || instr !== 32'h0 || instr_pc !== 64'h0) begin
      errors++; $display("FAIL reset_regs got pc=%h instr=%h ipc=%h want 0", pc, instr, instr_pc);
    end
    step();
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL boot_noreq got %b want 0", imem_req);
    end
    step();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      errors++; $display("FAIL first_req got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    int n;
    for (int a = 0; a < 16; a += 4) exp_q.push_back({64'(a), mem_word(64'(a))});
    instr_ready = 1'b1;
    n = 0;
    while (obs_q.size() < 4 && n < 40) begin step(); n++; end
    instr_ready = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL seq_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [95:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL seq_instr got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall();
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 64'h10 ||
          instr_pc !== 64'h10 || instr !== mem_word(64'h10)) begin
        errors++;
        $display("FAIL stall_hold got v=%b req=%b pc=%h ipc=%h instr=%h want 1/0/10/10/%h",
                 instr_valid, imem_req, pc, instr_pc, instr, mem_word(64'h10));
      end
      step();
    end
    exp_q.push_back({64'h10, mem_word(64'h10)});
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (pc !== 64'h14) begin errors++; $display("FAIL stall_advance got pc=%h want 14", pc); end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL stall_accept got n=%0d want 1 entry %h", obs_q.size(), exp_q[0]);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_redirect_wait();
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin step(); n++; end
    ack_lat = 3;
    redirect_valid = 1'b1; redirect_pc = 64'h8;
    step();
    redirect_valid = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (imem_addr !== 64'h8 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL kill_addr_hold got addr=%h req=%b v=%b want 8/1/0",
                           imem_addr, imem_req, instr_valid);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (imem_addr !== 64'h100 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL kill_retarget got addr=%h req=%b v=%b want 100/1/0",
                         imem_addr, imem_req, instr_valid);
    end
    ack_lat = 0;
    exp_q.push_back({64'h100, mem_word(64'h100)});
    instr_ready = 1'b1;
    n = 0;
    while (obs_q.size() < 1 && n < 20) begin step(); n++; end
    instr_ready = 1'b0;
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL kill_next got n=%0d want 1 entry %h", obs_q.size(), exp_q[0]);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_trap_priority();
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin step(); n++; end
    trap_valid = 1'b1; trap_vec = 64'h200;
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    step();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pc !== 64'h200 || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
      errors++; $display("FAIL trap_prio got pc=%h v=%b mis=%b want 200/0/0",
                         pc, instr_valid, misalign_err);
    end
    exp_q.push_back({64'h200, mem_word(64'h200)});
    instr_ready = 1'b1;
    n = 0;
    while (obs_q.size() < 1 && n < 20) begin step(); n++; end
    instr_ready = 1'b0;
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL trap_fetch got n=%0d want 1 entry %h", obs_q.size(), exp_q[0]);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_misalign_wrap();
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin step(); n++; end
    redirect_valid = 1'b1; redirect_pc = 64'h102;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b1 || pc !== 64'h100) begin
      errors++; $display("FAIL misalign_pulse got mis=%b pc=%h want 1/100", misalign_err, pc);
    end
    step();
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++; $display("FAIL misalign_clear got %b want 0", misalign_err);
    end
    exp_q.push_back({64'h100, mem_word(64'h100)});
    instr_ready = 1'b1;
    n = 0;
    while (obs_q.size() < 1 && n < 20) begin step(); n++; end
    instr_ready = 1'b0;
    n = 0;
    while (!instr_valid && n < 20) begin step(); n++; end
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b0 || pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL wrap_target got mis=%b pc=%h want 0/fffffffffffffffc", misalign_err, pc);
    end
    exp_q.push_back({64'hFFFF_FFFF_FFFF_FFFC, mem_word(64'hFFFF_FFFF_FFFF_FFFC)});
    exp_q.push_back({64'h0, mem_word(64'h0)});
    instr_ready = 1'b1;
    n = 0;
    while (obs_q.size() < 3 && n < 30) begin step(); n++; end
    instr_ready = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [95:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_instr got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n = 0;
    while (!instr_valid && n < 20) begin step(); n++; end
    checks++;
    if (pc !== 64'h4 || instr_pc !== 64'h4) begin
      errors++; $display("FAIL wrap_next got pc=%h ipc=%h want 4/4", pc, instr_pc);
    end
  endtask

  task automatic test_reset_midfetch();
    int n;
    auto_ack = 1'b0; man_ack = 1'b0;
    exp_q.push_back({64'h4, mem_word(64'h4)});
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h8) begin
      errors++; $display("FAIL mid_fetch got req=%b addr=%h want 1/8", imem_req, imem_addr);
    end
    step();
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || pc !== 64'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got req=%b pc=%h v=%b want 0/0/0", imem_req, pc, instr_valid);
    end
    step();
    resetn = 1'b1; man_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || pc !== 64'h0) begin
      errors++; $display("FAIL reboot got req=%b pc=%h want 0/0", imem_req, pc);
    end
    step();
    man_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h0 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL stale_ack got req=%b addr=%h v=%b want 1/0/0",
                           imem_req, imem_addr, instr_valid);
      end
      step();
    end
    auto_ack = 1'b1;
    exp_q.push_back({64'h0, mem_word(64'h0)});
    instr_ready = 1'b1;
    n = 0;
    while (obs_q.size() < 2 && n < 20) begin step(); n++; end
    instr_ready = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL reset_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [95:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_instr got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_trap_priority();
    test_misalign_wrap();
    test_reset_midfetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
